tft_spi_stream: RTL and testbench
=================================

TFT_SPI_STREAM -- requirements
Module: tft_spi_stream

Interface
REQ-001 Parameter CLK_DIV, default 2, meaning sysclk cycles per SPI half-period (legal range 1..255).
REQ-002 Parameter FIFO_DEPTH, default 16, meaning entries in the word FIFO (power of two, 2..256).
REQ-003 Parameter RST_CYCLES, default 1000, meaning sysclk cycles for each of the panel-reset low and post-reset wait phases.
REQ-004 Port: sysclk  input  1  system clock; all logic on its rising edge.
REQ-005 Port: rst  input  1  asynchronous, active-high reset.
REQ-006 Port: in_valid  input  1  word offered.
REQ-007 Port: in_ready  output  1  FIFO can accept a word this cycle.
REQ-008 Port: in_data  input  16  word; MSB-first; only [7:0] is used when in_wide=0.
REQ-009 Port: in_dc  input  1  0=command, 1=data; drives tft_dc for this word.
REQ-010 Port: in_wide  input  1  1=16-bit word, 0=8-bit word.
REQ-011 Port: busy  output  1  high during the reset sequence, while the FIFO is non-empty, or while shifting.
REQ-012 Ports: tft_rst, tft_cs, tft_dc, tft_clk, tft_din  output  1 each  panel pins; tft_rst and tft_cs are active-low.
REQ-013 Port: tft_bl  output  1  backlight; held high once the reset sequence completes.

Function
REQ-014 Handshake: a word is accepted on a sysclk edge where in_valid=1 and in_ready=1.
REQ-015 in_ready shall be 0 when the FIFO holds FIFO_DEPTH entries, and 0 throughout the reset sequence.
REQ-016 When the FIFO is full and a pop and a push occur in the same cycle, in_ready is already 0, so the push is not accepted.
REQ-017 State machine: RST_LOW -> RST_WAIT -> IDLE -> LOAD -> SHIFT_LO <-> SHIFT_HI -> (LOAD | END) -> IDLE.
REQ-018 RST_LOW: tft_rst=0 for RST_CYCLES cycles.
REQ-019 RST_WAIT: tft_rst=1 for RST_CYCLES cycles, then tft_bl=1.
REQ-020 IDLE: tft_cs=1; on a non-empty FIFO, transition to LOAD.
REQ-021 LOAD (1 cycle):
  - pop the FIFO head into the shift register;
  - bit counter := 16 if wide, else 8;
  - tft_dc := the word's dc;
  - tft_cs := 0;
  - tft_din := first bit (bit 15 if wide, else bit 7).
REQ-022 SPI mode 0: tft_clk idles low and each phase lasts CLK_DIV cycles; tft_din changes only while tft_clk is low; rising edge at the SHIFT_LO -> SHIFT_HI transition.
REQ-023 After SHIFT_HI, the counter decrements; if non-zero, shift the next bit out and return to SHIFT_LO.
REQ-024 At counter zero: if the FIFO is non-empty, go to LOAD with tft_cs held 0 (burst, no CS gap); otherwise go to END.
REQ-025 END: tft_clk=0 for CLK_DIV cycles with tft_cs=0, then tft_cs=1 and go to IDLE.
REQ-026 tft_dc is stable from LOAD until the last rising tft_clk of its word.
REQ-027 Frame bit count shall equal exactly 8 or 16 per word; no extra clock edges.
REQ-028 Divider counter width is $clog2(CLK_DIV+1); FIFO count width is $clog2(FIFO_DEPTH+1); FIFO pointers wrap modulo FIFO_DEPTH.
REQ-029 busy shall be 0 only in IDLE with an empty FIFO.

Reset
REQ-030 On rst=1, all outputs shall be forced asynchronously:
  - tft_rst=0, tft_cs=1, tft_clk=0, tft_din=0, tft_dc=0, tft_bl=0;
  - in_ready=0, busy=1.
REQ-031 On rst=1, the FIFO shall be emptied and the state machine forced to RST_LOW.
REQ-032 rst asserted mid-frame shall abort the frame (CS released immediately) and discard every queued word.

Structure
REQ-033 Package tft_pkg shall hold the state enum, the SPI mode constants, and a word type {dc, wide, data[15:0]} (18 bits).
REQ-034 Sub-module tft_word_fifo (synchronous, FIFO_DEPTH x 18) shall provide push/pop/full/empty/count; the top shall contain the FSM, the divider and the shifter.

Verification (CLK_DIV=2, RST_CYCLES=4, FIFO_DEPTH=4)
REQ-035 Release rst:
  - tft_rst low for 4 cycles, high for 4 cycles;
  - then tft_bl=1 and in_ready=1, 8 cycles after release.
REQ-036 Push cmd 0x2A (dc=0, wide=0):
  - tft_dc=0;
  - exactly 8 tft_clk rising edges;
  - sampled bits 0,0,1,0,1,0,1,0;
  - tft_cs returns high 2 cycles after the last falling edge.
REQ-037 Push 16-bit data 0xF800 then 0x07E0 back-to-back:
  - single CS-low window with 32 rising edges;
  - tft_dc=1 throughout;
  - sampled bits match MSB-first.
REQ-038 Push 5 words while the shifter is stalled: in_ready drops after 4 accepted; the 5th word is not accepted until the first pop.
REQ-039 Assert rst at the 5th rising edge of a frame with 3 words queued: tft_cs=1 and tft_clk=0 immediately; after the reset sequence, no residual word is transmitted.
REQ-040 Ready/valid backpressure with random in_valid over 50 words: transmitted stream equals pushed stream, with no drops and no duplicates.

Source files
------------

// File: rtl/tft_pkg.sv
// Shared types for the TFT SPI streamer: FSM states, SPI mode constants and
// the queued word format.
package tft_pkg;

  typedef enum logic [2:0] {
    ST_RST_LOW,
    ST_RST_WAIT,
    ST_IDLE,
    ST_LOAD,
    ST_SHIFT_LO,
    ST_SHIFT_HI,
    ST_END
  } tft_state_e;

  // Mode 0: clock idles low, data sampled by the panel on the rising edge.
  localparam logic SPI_CPOL = 1'b0;
  localparam logic SPI_CPHA = 1'b0;

  typedef struct packed {
    logic        dc;
    logic        wide;
    logic [15:0] data;
  } tft_word_t;

  localparam int WORD_W = $bits(tft_word_t);

endpackage

// File: rtl/tft_word_fifo.sv
// Synchronous word FIFO; pushes are ignored when full and pops when empty.
module tft_word_fifo
  import tft_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic                       sysclk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [WORD_W-1:0]          wdata,
  input  logic                       pop,
  output logic [WORD_W-1:0]          rdata,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH+1);

  logic [WORD_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic              do_push;
  logic              do_pop;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge sysclk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  // Storage needs no reset; the pointers alone define validity.
  always_ff @(posedge sysclk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/tft_spi_stream.sv
// Streams queued command/data words to a TFT panel over mode-0 SPI after
// sequencing the panel reset and enabling the backlight.
module tft_spi_stream
  import tft_pkg::*;
#(
  parameter int CLK_DIV    = 2,
  parameter int FIFO_DEPTH = 16,
  parameter int RST_CYCLES = 1000
) (
  input  logic        sysclk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] in_data,
  input  logic        in_dc,
  input  logic        in_wide,
  output logic        busy,
  output logic        tft_rst,
  output logic        tft_cs,
  output logic        tft_dc,
  output logic        tft_clk,
  output logic        tft_din,
  output logic        tft_bl
);

  localparam int DIV_W = $clog2(CLK_DIV+1);
  localparam int RST_W = $clog2(RST_CYCLES+1);
  localparam int CNT_W = $clog2(FIFO_DEPTH+1);
  localparam logic [DIV_W-1:0] DIV_LOAD = DIV_W'(CLK_DIV-1);
  localparam logic [RST_W-1:0] RST_LOAD = RST_W'(RST_CYCLES-1);

  tft_state_e        state;
  logic [DIV_W-1:0]  div_cnt;
  logic [RST_W-1:0]  rst_cnt;
  logic [4:0]        bit_cnt;
  logic [15:0]       shreg;
  logic              ready_en;
  logic              fifo_push;
  logic              fifo_pop;
  logic              fifo_full;
  logic              fifo_empty;
  logic [CNT_W-1:0]  fifo_count;
  logic [WORD_W-1:0] fifo_rdata;
  tft_word_t         head;

  assign head      = tft_word_t'(fifo_rdata);
  assign in_ready  = ready_en & ~fifo_full;
  assign fifo_push = in_valid & in_ready;
  assign fifo_pop  = (state == ST_LOAD);
  assign busy      = ~((state == ST_IDLE) && (fifo_count == '0));

  tft_word_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .sysclk (sysclk),
    .rst    (rst),
    .push   (fifo_push),
    .wdata  ({in_dc, in_wide, in_data}),
    .pop    (fifo_pop),
    .rdata  (fifo_rdata),
    .full   (fifo_full),
    .empty  (fifo_empty),
    .count  (fifo_count)
  );

  always_ff @(posedge sysclk or posedge rst) begin
    if (rst) begin
      state    <= ST_RST_LOW;
      rst_cnt  <= RST_LOAD;
      div_cnt  <= '0;
      bit_cnt  <= '0;
      shreg    <= '0;
      ready_en <= 1'b0;
      tft_rst  <= 1'b0;
      tft_cs   <= 1'b1;
      tft_dc   <= 1'b0;
      tft_clk  <= SPI_CPOL;
      tft_din  <= 1'b0;
      tft_bl   <= 1'b0;
    end else begin
      case (state)
        ST_RST_LOW:
          if (rst_cnt == '0) begin
            state   <= ST_RST_WAIT;
            rst_cnt <= RST_LOAD;
            tft_rst <= 1'b1;
          end else rst_cnt <= rst_cnt - 1'b1;
        ST_RST_WAIT:
          if (rst_cnt == '0) begin
            state    <= ST_IDLE;
            tft_bl   <= 1'b1;
            ready_en <= 1'b1;
          end else rst_cnt <= rst_cnt - 1'b1;
        ST_IDLE:
          if (!fifo_empty) state <= ST_LOAD;
        ST_LOAD: begin
          // Narrow words are left-aligned so the shifter always emits bit 15.
          shreg   <= head.wide ? head.data : {head.data[7:0], 8'h00};
          bit_cnt <= head.wide ? 5'd16 : 5'd8;
          tft_din <= head.wide ? head.data[15] : head.data[7];
          tft_dc  <= head.dc;
          tft_cs  <= 1'b0;
          div_cnt <= DIV_LOAD;
          state   <= ST_SHIFT_LO;
        end
        ST_SHIFT_LO:
          if (div_cnt == '0) begin
            tft_clk <= ~SPI_CPOL;
            div_cnt <= DIV_LOAD;
            state   <= ST_SHIFT_HI;
          end else div_cnt <= div_cnt - 1'b1;
        ST_SHIFT_HI:
          if (div_cnt == '0) begin
            tft_clk <= SPI_CPOL;
            div_cnt <= DIV_LOAD;
            bit_cnt <= bit_cnt - 1'b1;
            if (bit_cnt != 5'd1) begin
              shreg   <= {shreg[14:0], 1'b0};
              tft_din <= shreg[14];
              state   <= ST_SHIFT_LO;
            end else if (!fifo_empty) begin
              state <= ST_LOAD;
            end else begin
              state <= ST_END;
            end
          end else div_cnt <= div_cnt - 1'b1;
        ST_END:
          if (div_cnt == '0) begin
            tft_cs <= 1'b1;
            state  <= ST_IDLE;
          end else div_cnt <= div_cnt - 1'b1;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tft_spi_stream.sv
// Directed bench for tft_spi_stream: reset sequencing, framed words, FIFO
// backpressure, mid-frame reset and a randomised valid stream.
module tb_tft_spi_stream;

  localparam int CLK_DIV    = 2;
  localparam int FIFO_DEPTH = 4;
  localparam int RST_CYCLES = 4;

  logic        sysclk = 1'b0;
  logic        rst = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_dc = 1'b0;
  logic        in_wide = 1'b0;
  logic [15:0] in_data = '0;
  logic        in_ready, busy, tft_rst, tft_cs, tft_dc, tft_clk, tft_din, tft_bl;

  int checks = 0;
  int failures = 0;

  always #5 sysclk = ~sysclk;

  tft_spi_stream #(
    .CLK_DIV(CLK_DIV), .FIFO_DEPTH(FIFO_DEPTH), .RST_CYCLES(RST_CYCLES)
  ) dut (
    .sysclk(sysclk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_dc(in_dc), .in_wide(in_wide), .busy(busy),
    .tft_rst(tft_rst), .tft_cs(tft_cs), .tft_dc(tft_dc), .tft_clk(tft_clk),
    .tft_din(tft_din), .tft_bl(tft_bl)
  );

  // Panel-side monitor
  int   cyc = 0;
  int   rise_cnt = 0;
  int   windows = 0;
  int   cs_bad = 0;
  int   last_fall = 0;
  int   cs_gap = 0;
  logic got_bits[$];
  logic got_dc[$];
  logic exp_bits[$];
  logic exp_dc[$];

  always @(posedge sysclk) cyc <= cyc + 1;
  always @(posedge tft_clk) begin
    rise_cnt++;
    got_bits.push_back(tft_din);
    got_dc.push_back(tft_dc);
    if (tft_cs !== 1'b0) cs_bad++;
  end
  always @(negedge tft_clk) last_fall = cyc;
  always @(posedge tft_cs) cs_gap = cyc - last_fall;
  always @(negedge tft_cs) windows++;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, req, req);
    end
  endtask

  function automatic void add_exp(input logic dc, input logic wide, input logic [15:0] d);
    int n;
    n = wide ? 16 : 8;
    for (int i = n - 1; i >= 0; i--) begin
      exp_bits.push_back(d[i]);
      exp_dc.push_back(dc);
    end
  endfunction

  task automatic check_stream(input string name, input int base);
    int nb, bad_bits, bad_dc;
    nb = got_bits.size() - base;
    bad_bits = 0;
    bad_dc = 0;
    check({name, " bit count"}, nb, exp_bits.size());
    for (int i = 0; i < exp_bits.size() && i < nb; i++) begin
      if (got_bits[base+i] !== exp_bits[i]) bad_bits++;
      if (got_dc[base+i] !== exp_dc[i]) bad_dc++;
    end
    check({name, " bit errors"}, bad_bits, 0);
    check({name, " dc errors"}, bad_dc, 0);
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while (busy !== 1'b0 && n < 3000) begin
      @(negedge sysclk);
      n++;
    end
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL %s idle timeout: busy=%b expected 0", name, busy);
    end
  endtask

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic push_word(input logic dc, input logic wide, input logic [15:0] d, output int waited);
    in_dc = dc;
    in_wide = wide;
    in_data = d;
    in_valid = 1'b1;
    waited = 0;
    while (in_ready !== 1'b1 && waited < 500) begin
      @(negedge sysclk);
      waited++;
    end
    if (in_ready !== 1'b1) begin
      failures++;
      $display("FAIL push timeout: in_ready=%b expected 1", in_ready);
    end else begin
      add_exp(dc, wide, d);
    end
    @(negedge sysclk);
    in_valid = 1'b0;
  endtask

  typedef struct {
    logic        dc;
    logic        wide;
    logic [15:0] data;
    int          grp;
  } vec_t;

  initial begin
    vec_t        vecs[6];
    int          grp_edges[4];
    int          base_bits, base_rise, base_win, base_bad, w, wsum, n, sent;
    int          first_rst_hi, first_rdy, first_bl;
    logic [7:0]  got8;
    logic [15:0] rd;
    logic        rdc, rwide, acc;

    vecs[0] = '{1'b0, 1'b0, 16'h002A, 0};
    vecs[1] = '{1'b1, 1'b1, 16'hF800, 1};
    vecs[2] = '{1'b1, 1'b1, 16'h07E0, 1};
    vecs[3] = '{1'b1, 1'b0, 16'h00A5, 2};
    vecs[4] = '{1'b0, 1'b1, 16'h1234, 2};
    vecs[5] = '{1'b1, 1'b0, 16'h0080, 3};
    grp_edges = '{8, 32, 24, 8};

    // Reset state
    #2 rst = 1'b1;
    repeat (3) @(negedge sysclk);
    check("rst tft_rst", tft_rst, 0);
    check("rst tft_cs", tft_cs, 1);
    check("rst tft_clk", tft_clk, 0);
    check("rst tft_din", tft_din, 0);
    check("rst tft_dc", tft_dc, 0);
    check("rst tft_bl", tft_bl, 0);
    check("rst in_ready", in_ready, 0);
    check("rst busy", busy, 1);

    // Panel reset sequence
    rst = 1'b0;
    first_rst_hi = -1;
    first_rdy = -1;
    first_bl = -1;
    for (int c = 1; c <= 12; c++) begin
      @(negedge sysclk);
      if (tft_rst === 1'b1 && first_rst_hi < 0) first_rst_hi = c;
      if (in_ready === 1'b1 && first_rdy < 0) first_rdy = c;
      if (tft_bl === 1'b1 && first_bl < 0) first_bl = c;
    end
    check("seq tft_rst high cycle", first_rst_hi, 4);
    check("seq in_ready cycle", first_rdy, 8);
    check("seq tft_bl cycle", first_bl, 8);

    // Table-driven frames; each group is pushed back-to-back into one CS window
    for (int g = 0; g < 4; g++) begin
      exp_bits.delete();
      exp_dc.delete();
      base_bits = got_bits.size();
      base_rise = rise_cnt;
      base_win = windows;
      base_bad = cs_bad;
      for (int i = 0; i < 6; i++)
        if (vecs[i].grp == g) push_word(vecs[i].dc, vecs[i].wide, vecs[i].data, w);
      wait_idle($sformatf("grp%0d", g));
      check($sformatf("grp%0d rising edges", g), rise_cnt - base_rise, grp_edges[g]);
      check($sformatf("grp%0d cs windows", g), windows - base_win, 1);
      check($sformatf("grp%0d cs gap", g), cs_gap, CLK_DIV);
      check($sformatf("grp%0d edges with cs high", g), cs_bad - base_bad, 0);
      check_stream($sformatf("grp%0d", g), base_bits);
      if (g == 0) begin
        got8 = '0;
        for (int i = 0; i < 8; i++) got8 = {got8[6:0], got_bits[base_bits+i]};
        check("cmd 0x2A sampled bits", got8, 8'h2A);
      end
    end

    // FIFO fill while shifting: four accepted, fifth waits for the next pop
    exp_bits.delete();
    exp_dc.delete();
    base_bits = got_bits.size();
    base_rise = rise_cnt;
    base_win = windows;
    push_word(1'b1, 1'b1, 16'hC3A5, w);
    @(negedge sysclk);
    @(negedge sysclk);
    wsum = 0;
    push_word(1'b1, 1'b0, 16'h0011, w); wsum += w;
    push_word(1'b0, 1'b1, 16'h2233, w); wsum += w;
    push_word(1'b1, 1'b0, 16'h0044, w); wsum += w;
    push_word(1'b1, 1'b1, 16'h5566, w); wsum += w;
    check("stall first four waits", wsum, 0);
    check("stall in_ready when full", in_ready, 0);
    push_word(1'b0, 1'b0, 16'h0077, w);
    check("stall fifth accepted after first word", rise_cnt - base_rise, 16);
    wait_idle("stall");
    check("stall cs windows", windows - base_win, 1);
    check_stream("stall", base_bits);

    // Reset at the fifth rising edge of a frame with three words queued
    base_rise = rise_cnt;
    push_word(1'b1, 1'b0, 16'h0011, w);
    push_word(1'b1, 1'b0, 16'h0022, w);
    push_word(1'b1, 1'b0, 16'h0033, w);
    push_word(1'b1, 1'b0, 16'h0044, w);
    n = 0;
    while (rise_cnt - base_rise < 5 && n < 400) begin
      @(posedge sysclk);
      #1;
      n++;
    end
    check("abort trigger edge count", rise_cnt - base_rise, 5);
    rst = 1'b1;
    #1;
    check("abort tft_cs", tft_cs, 1);
    check("abort tft_clk", tft_clk, 0);
    check("abort in_ready", in_ready, 0);
    @(negedge sysclk);
    @(negedge sysclk);
    rst = 1'b0;
    n = 0;
    while (tft_bl !== 1'b1 && n < 40) begin
      @(negedge sysclk);
      n++;
    end
    check("abort reset sequence done", tft_bl, 1);
    base_rise = rise_cnt;
    base_win = windows;
    repeat (60) @(negedge sysclk);
    check("abort residual edges", rise_cnt - base_rise, 0);
    check("abort residual windows", windows - base_win, 0);
    check("abort busy", busy, 0);
    exp_bits.delete();
    exp_dc.delete();
    base_bits = got_bits.size();
    push_word(1'b1, 1'b0, 16'h005A, w);
    wait_idle("recovery");
    check_stream("recovery", base_bits);

    // Random in_valid over 50 words
    exp_bits.delete();
    exp_dc.delete();
    base_bits = got_bits.size();
    sent = 0;
    n = 0;
    rd = 16'($urandom);
    rdc = 1'($urandom_range(0, 1));
    rwide = 1'($urandom_range(0, 1));
    while (sent < 50 && n < 20000) begin
      in_data = rd;
      in_dc = rdc;
      in_wide = rwide;
      in_valid = ($urandom_range(0, 1) == 1);
      acc = in_valid && (in_ready === 1'b1);
      @(negedge sysclk);
      n++;
      if (acc) begin
        add_exp(rdc, rwide, rd);
        sent++;
        rd = 16'($urandom);
        rdc = 1'($urandom_range(0, 1));
        rwide = 1'($urandom_range(0, 1));
      end
    end
    in_valid = 1'b0;
    check("random words accepted", sent, 50);
    wait_idle("random");
    check_stream("random", base_bits);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
